// File: rtl/cnn_pkg.sv
// Shared CNN definitions: collector FSM states, default data widths and the
// output-map size helper used to size the feature-map buffer.
package cnn_pkg;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 12;

  function automatic int fmap_dim(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port feature-map buffer: one write port and one registered read
// port. The read register only updates on rd_en_i, so it holds data during stalls.
module fmap_ram #(
  parameter int DEPTH = 64,
  parameter int DW    = 16,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/conv_fmap_collector.sv
// Captures one convolver output frame into an M x M buffer and replays it as a
// ready/valid stream. Define CONV_COLLECT_RELU_EN to clamp negative words to 0 on capture.
module conv_fmap_collector
  import cnn_pkg::*;
#(
  parameter logic [8:0] n     = 9'h00a,
  parameter logic [8:0] k     = 9'h003,
  parameter int         s     = 1,
  parameter int         N     = DATA_W,
  parameter int         Q     = FRAC_W,
  localparam int        M     = fmap_dim(int'(n), int'(k), s),
  localparam int        DEPTH = M * M,
  localparam int        AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int        CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          global_rst,
  input  logic          start,
  input  logic [N-1:0]  conv_op,
  input  logic          valid_conv,
  input  logic          end_conv,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          done,
  output logic [CW-1:0] word_count,
  output logic          err_overflow,
  output logic          err_short
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (Q >= N) begin : g_bad_frac_w
    $error("conv_fmap_collector: Q must be smaller than N");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_short_q, err_short_d;
  logic          wr_en, rd_en, xfer;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  wr_data;

`ifdef CONV_COLLECT_RELU_EN
  assign wr_data = conv_op[N-1] ? '0 : conv_op;
`else
  assign wr_data = conv_op;
`endif

  assign count_inc  = count_q + CW'(1);
  assign rd_ptr_inc = rd_ptr_q + CW'(1);
  assign xfer       = out_valid_q & out_ready;

  // NOTE: every output of this block gets a default first, so no latches can be inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = 1'b0;
    err_ovf_d   = err_ovf_q;
    err_short_d = err_short_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr_q[AW-1:0];

    unique case (state_q)
      S_COLLECT: begin
        // A write in the same cycle as end_conv is kept before the short-frame check.
        if (valid_conv) begin
          wr_en   = 1'b1;
          count_d = count_inc;
          if (count_inc == FULL) begin
            state_d = S_DRAIN;
          end else if (end_conv) begin
            err_short_d = 1'b1;
            state_d     = S_DRAIN;
          end
        end else if (end_conv) begin
          err_short_d = 1'b1;
          state_d     = (count_q == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          rd_en       = 1'b1;
          out_valid_d = 1'b1;
        end else if (xfer) begin
          rd_ptr_d = rd_ptr_inc;
          if (out_last_q) begin
            out_valid_d = 1'b0;
            state_d     = S_DONE;
          end else begin
            // Read ahead so the next word lands on the same edge as the transfer.
            rd_en   = 1'b1;
            rd_addr = rd_ptr_inc[AW-1:0];
          end
        end
        out_last_d = out_valid_d & (rd_ptr_d == count_q - CW'(1));
      end
      S_DONE: begin
        if (start) begin
          count_d     = '0;
          rd_ptr_d    = '0;
          err_ovf_d   = 1'b0;
          err_short_d = 1'b0;
          state_d     = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase

    if (valid_conv && !wr_en) begin
      err_ovf_d = 1'b1;
    end
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_q     <= S_COLLECT;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_ovf_q   <= err_ovf_d;
      err_short_q <= err_short_d;
    end
  end

  fmap_ram #(
    .DEPTH (DEPTH),
    .DW    (N),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst_i     (global_rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (count_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (out_data)
  );

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign done         = done_q;
  assign word_count   = count_q;
  assign err_overflow = err_ovf_q;
  assign err_short    = err_short_q;

endmodule

// File: tb/tb_conv_fmap_collector.sv
// Bench for conv_fmap_collector (n=10, k=3, s=1 -> 8x8 frame): scoreboard of
// expected replay words, plus a capture table whose expectations follow CONV_COLLECT_RELU_EN.
module tb_conv_fmap_collector;

  logic        clk = 1'b0;
  logic        global_rst, start, valid_conv, end_conv, out_ready;
  logic [15:0] conv_op;
  logic [15:0] out_data;
  logic        out_valid, out_last, done, err_overflow, err_short;
  logic [6:0]  word_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          exp_len = 0;
  int          rx_cnt = 0;
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  bit          chk_done_next = 1'b0;

  typedef struct packed {
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;
  vec_t vecs[6];

  conv_fmap_collector #(.n(9'h00a), .k(9'h003), .s(1), .N(16), .Q(12)) dut (
    .clk          (clk),
    .global_rst   (global_rst),
    .start        (start),
    .conv_op      (conv_op),
    .valid_conv   (valid_conv),
    .end_conv     (end_conv),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .done         (done),
    .word_count   (word_count),
    .err_overflow (err_overflow),
    .err_short    (err_short)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input bit keep);
    conv_op    = w;
    valid_conv = 1'b1;
    if (keep) exp_q.push_back(w);
    tick();
    valid_conv = 1'b0;
  endtask

  task automatic pulse_end();
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
  endtask

  task automatic start_frame(input int len);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.delete();
    rx_cnt  = 0;
    exp_len = len;
    check("cleared after start", {done, err_overflow, err_short, word_count}, 32'h0);
  endtask

  task automatic wait_done(input int limit, input bit toggle);
    int c = 0;
    while (!done && c < limit) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      c++;
    end
    out_ready = 1'b1;
    check("done reached", done, 1);
    check("words replayed", rx_cnt, exp_len);
    check("scoreboard empty", exp_q.size(), 0);
  endtask

  // Scoreboard side: the head of the queue must be on out_data whenever out_valid is high.
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_done_next) check("done after last", {done, out_valid}, 2'b10);
      if (stall_prev) check("valid held in stall", out_valid, 1);
      chk_done_next = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected word", exp_q.size(), 1);
        end else begin
          check("out_data", out_data, exp_q[0]);
          check("out_last", out_last, (rx_cnt == exp_len - 1));
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          rx_cnt++;
          chk_done_next = out_last;
        end
      end
      stall_prev = out_valid & ~out_ready;
    end else begin
      stall_prev    = 1'b0;
      chk_done_next = 1'b0;
    end
  end

  initial begin
    int lat;
`ifdef CONV_COLLECT_RELU_EN
    vecs[0] = '{16'hF000, 16'h0000};
    vecs[1] = '{16'h0800, 16'h0800};
    vecs[2] = '{16'h8000, 16'h0000};
    vecs[3] = '{16'h7FFF, 16'h7FFF};
    vecs[4] = '{16'hFFFF, 16'h0000};
    vecs[5] = '{16'h0001, 16'h0001};
`else
    vecs[0] = '{16'hF000, 16'hF000};
    vecs[1] = '{16'h0800, 16'h0800};
    vecs[2] = '{16'h8000, 16'h8000};
    vecs[3] = '{16'h7FFF, 16'h7FFF};
    vecs[4] = '{16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h0001, 16'h0001};
`endif

    global_rst = 1'b1;
    start      = 1'b0;
    valid_conv = 1'b0;
    end_conv   = 1'b0;
    conv_op    = '0;
    out_ready  = 1'b1;
    repeat (3) tick();
    check("reset flags", {out_valid, out_last, done, err_overflow, err_short}, 5'b0);
    check("reset word_count", word_count, 0);
    check("reset out_data", out_data, 0);
    global_rst = 1'b0;

    // Full frame 0..63 with out_ready held high.
    exp_len = 64;
    mon_en  = 1'b1;
    for (int i = 0; i < 64; i++) send_word(16'(i), 1'b1);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("first valid latency", lat, 2);
    check("full word_count", word_count, 64);
    wait_done(200, 1'b0);
    check("no errors frame 1", {err_overflow, err_short}, 2'b00);

    // Same frame with out_ready toggling every cycle.
    start_frame(64);
    for (int i = 0; i < 64; i++) send_word(16'(i), 1'b1);
    wait_done(400, 1'b1);
    check("no errors frame 2", {err_overflow, err_short}, 2'b00);

    // Short frame: end_conv after 40 words; a stray start mid-collection is ignored.
    start_frame(40);
    for (int i = 0; i < 40; i++) begin
      send_word(16'(100 + 3 * i), 1'b1);
      if (i == 19) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start ignored in collect", word_count, 20);
      end
    end
    pulse_end();
    check("short err_short", err_short, 1);
    check("short word_count", word_count, 40);
    wait_done(200, 1'b0);

    // 65th word arriving in the drain entry cycle is dropped.
    start_frame(64);
    for (int i = 0; i < 64; i++) send_word(16'(i) ^ 16'hA5A5, 1'b1);
    send_word(16'hDEAD, 1'b0);
    check("overflow flag", err_overflow, 1);
    wait_done(200, 1'b0);
    check("overflow sticky", err_overflow, 1);

    // Capture table: clamp behaviour depends on the build.
    start_frame(6);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].dout);
      send_word(vecs[i].din, 1'b0);
    end
    pulse_end();
    check("table word_count", word_count, 6);
    wait_done(100, 1'b0);

    // Reset in the middle of a drain.
    start_frame(64);
    for (int i = 0; i < 64; i++) send_word(16'(7 * i), 1'b1);
    repeat (12) tick();
    check("mid-drain valid", out_valid, 1);
    mon_en     = 1'b0;
    global_rst = 1'b1;
    tick();
    check("rst mid-drain flags", {out_valid, out_last, done, err_overflow, err_short}, 5'b0);
    check("rst mid-drain count", word_count, 0);
    check("rst mid-drain data", out_data, 0);
    global_rst = 1'b0;
    exp_q.delete();
    rx_cnt  = 0;
    exp_len = 64;
    mon_en  = 1'b1;
    for (int i = 0; i < 64; i++) send_word(16'(16'h4000 + i), 1'b1);
    wait_done(200, 1'b0);

    // Re-arm after a full frame and capture from address 0 again.
    start_frame(3);
    for (int i = 0; i < 3; i++) send_word(16'(16'h1230 + i), 1'b1);
    pulse_end();
    wait_done(100, 1'b0);

    mon_en = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
